// File: rtl/ddr3_write_burst8.sv
// DDR3 write burst-of-8 launcher: indexed load buffer, write latency wait,
// DQS preamble, 8 DQ beats with toggling DQS, postamble.
module ddr3_write_burst8 #(
   parameter int WL = 10,
   parameter int DW = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_en,
   input  logic [2:0]        load_ptr,
   input  logic [DW-1:0]     load_data,
   input  logic [DW/8-1:0]   load_mask,
   output logic              load_ready,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [DW-1:0]     dq_out,
   output logic [DW/8-1:0]   dm_out,
   output logic              dq_oe,
   output logic              dqs_out,
   output logic              dqs_oe
);

   localparam int MW = DW / 8;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WAIT  = 3'd1;
   localparam logic [2:0] S_PRE   = 3'd2;
   localparam logic [2:0] S_BURST = 3'd3;
   localparam logic [2:0] S_POST  = 3'd4;

   // WAIT length; zero means start goes straight to preamble
   localparam logic [5:0] LAT0 = 6'(WL - 3);

   logic [2:0]    state;
   logic [2:0]    beat;
   logic [2:0]    beat_nx;
   logic [5:0]    lat;
   logic [DW-1:0] r [8];
   logic [MW-1:0] m [8];

   assign beat_nx    = beat + 3'd1;
   assign load_ready = ~busy;

   // Burst buffer: writable only while no burst is in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            r[i] <= '0;
            m[i] <= '0;
         end
      end else if (load_en && !busy) begin
         r[load_ptr] <= load_data;
         m[load_ptr] <= load_mask;
      end
   end

   // Sequencer: outputs are registered alongside the state they belong to
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         beat    <= 3'd0;
         lat     <= 6'd0;
         busy    <= 1'b0;
         done    <= 1'b0;
         dq_out  <= '0;
         dm_out  <= '0;
         dq_oe   <= 1'b0;
         dqs_out <= 1'b0;
         dqs_oe  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (LAT0 == 6'd0) begin
                     state  <= S_PRE;
                     lat    <= 6'd1;
                     dqs_oe <= 1'b1;
                  end else begin
                     state <= S_WAIT;
                     lat   <= LAT0;
                  end
               end
            end
            S_WAIT: begin
               if (lat == 6'd1) begin
                  state  <= S_PRE;
                  lat    <= 6'd1;
                  dqs_oe <= 1'b1;
               end else begin
                  lat <= lat - 6'd1;
               end
            end
            S_PRE: begin
               if (lat == 6'd0) begin
                  state   <= S_BURST;
                  dq_oe   <= 1'b1;
                  dq_out  <= r[beat];
                  dm_out  <= m[beat];
                  dqs_out <= ~beat[0];
               end else begin
                  lat <= lat - 6'd1;
               end
            end
            S_BURST: begin
               beat <= beat_nx;
               if (beat == 3'd7) begin
                  state   <= S_POST;
                  dq_oe   <= 1'b0;
                  dq_out  <= '0;
                  dm_out  <= '0;
                  dqs_out <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  dq_out  <= r[beat_nx];
                  dm_out  <= m[beat_nx];
                  dqs_out <= beat[0];
               end
            end
            S_POST: begin
               state  <= S_IDLE;
               busy   <= 1'b0;
               done   <= 1'b0;
               dqs_oe <= 1'b0;
            end
            default: begin
               state   <= S_IDLE;
               beat    <= 3'd0;
               lat     <= 6'd0;
               busy    <= 1'b0;
               done    <= 1'b0;
               dq_out  <= '0;
               dm_out  <= '0;
               dq_oe   <= 1'b0;
               dqs_out <= 1'b0;
               dqs_oe  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ddr3_write_burst8.sv
// Bench for ddr3_write_burst8: WL=10 and WL=3 instances on shared stimulus,
// checked every cycle against a timeline model of the burst.
module tb_ddr3_write_burst8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load_en = 1'b0;
   logic [2:0]  load_ptr = '0;
   logic [15:0] load_data = '0;
   logic [1:0]  load_mask = '0;
   logic        start = 1'b0;

   logic [1:0]       busy_v, done_v, lr_v, dqoe_v, dqsoe_v, dqs_v;
   logic [1:0][15:0] dq_v;
   logic [1:0][1:0]  dm_v;

   int wl [2] = '{10, 3};
   bit act [2];
   int s [2];
   logic [15:0] md [2][8];
   logic [15:0] sd [2][8];
   logic [1:0]  mm [2][8];
   logic [1:0]  sm [2][8];
   int edge_n = 0;
   int nchk = 0;
   int npass = 0;

   always #5 clk = ~clk;

   ddr3_write_burst8 #(.WL(10), .DW(16)) u10 (
      .clk(clk), .reset(reset), .load_en(load_en),
      .load_ptr(load_ptr), .load_data(load_data),
      .load_mask(load_mask), .load_ready(lr_v[0]),
      .start(start), .busy(busy_v[0]), .done(done_v[0]),
      .dq_out(dq_v[0]), .dm_out(dm_v[0]), .dq_oe(dqoe_v[0]),
      .dqs_out(dqs_v[0]), .dqs_oe(dqsoe_v[0]));

   ddr3_write_burst8 #(.WL(3), .DW(16)) u3 (
      .clk(clk), .reset(reset), .load_en(load_en),
      .load_ptr(load_ptr), .load_data(load_data),
      .load_mask(load_mask), .load_ready(lr_v[1]),
      .start(start), .busy(busy_v[1]), .done(done_v[1]),
      .dq_out(dq_v[1]), .dm_out(dm_v[1]), .dq_oe(dqoe_v[1]),
      .dqs_out(dqs_v[1]), .dqs_oe(dqsoe_v[1]));

   // {busy, done, load_ready, dq_oe, dqs_oe, dqs_out, dm, dq}
   function automatic logic [23:0] obs(int i);
      return {busy_v[i], done_v[i], lr_v[i], dqoe_v[i],
              dqsoe_v[i], dqs_v[i], dm_v[i], dq_v[i]};
   endfunction

   // Outputs seen after edge edge_n are spec edge n = edge_n - s + 1
   function automatic logic [23:0] expv(int i);
      logic [23:0] v;
      int n;
      int k;
      v = 24'h0;
      v[21] = 1'b1;
      n = edge_n - s[i] + 1;
      if (act[i] && n <= wl[i] + 8) begin
         v[23] = 1'b1;
         v[21] = 1'b0;
         if (n >= wl[i] - 2) v[19] = 1'b1;
         if (n >= wl[i] && n <= wl[i] + 7) begin
            k = n - wl[i];
            v[20] = 1'b1;
            v[18] = (k % 2 == 0);
            v[17:16] = sm[i][k];
            v[15:0] = sd[i][k];
         end
         if (n == wl[i] + 8) v[22] = 1'b1;
      end
      return v;
   endfunction

   task automatic check(string tag, logic [23:0] got,
                        logic [23:0] exp);
      nchk++;
      if (got !== exp)
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      else
         npass++;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 2; i++) begin
         act[i] = 1'b0;
         for (int k = 0; k < 8; k++) begin
            md[i][k] = '0;
            mm[i][k] = '0;
         end
      end
   endtask

   task automatic model_edge(int i);
      bit bz;
      bz = act[i] && (edge_n - s[i]) <= wl[i] + 8;
      if (!bz) begin
         if (load_en) begin
            md[i][load_ptr] = load_data;
            mm[i][load_ptr] = load_mask;
         end
         if (start) begin
            act[i] = 1'b1;
            s[i] = edge_n;
            for (int k = 0; k < 8; k++) begin
               sd[i][k] = md[i][k];
               sm[i][k] = mm[i][k];
            end
         end
      end
   endtask

   task automatic check_all(string what);
      for (int i = 0; i < 2; i++)
         check($sformatf("%s wl%0d e%0d", what, wl[i], edge_n),
               obs(i), expv(i));
   endtask

   task automatic step(input logic le, input logic [2:0] p,
                       input logic [15:0] d, input logic [1:0] mk,
                       input logic st);
      load_en = le;
      load_ptr = p;
      load_data = d;
      load_mask = mk;
      start = st;
      @(posedge clk);
      edge_n++;
      for (int i = 0; i < 2; i++) model_edge(i);
      #1;
      check_all("cyc");
   endtask

   task automatic idle(int n);
      repeat (n) step(1'b0, 3'd0, 16'h0, 2'b00, 1'b0);
   endtask

   task automatic do_reset();
      load_en = 1'b0;
      start = 1'b0;
      #1 reset = 1'b1;
      model_clear();
      #1 check_all("rst_async");
      @(posedge clk);
      edge_n++;
      #1 check_all("rst_hold");
      #2 reset = 1'b0;
   endtask

   task automatic load_rand();
      for (int k = 0; k < 8; k++)
         step(1'b1, 3'(k), 16'($urandom), 2'($urandom), 1'b0);
   endtask

   initial begin
      model_clear();
      #2 check_all("rst_init");
      @(posedge clk);
      edge_n++;
      #1 check_all("rst_hold");
      #2 reset = 1'b0;
      idle(20);

      // nominal burst
      for (int k = 0; k < 8; k++)
         step(1'b1, 3'(k), 16'(16'h1110 + k), 2'b00, 1'b0);
      step(1'b0, 3'd0, 16'h0, 2'b00, 1'b1);
      idle(24);

      // reverse load order with one masked beat
      for (int k = 7; k >= 0; k--)
         step(1'b1, 3'(k), 16'($urandom),
              (k == 3) ? 2'b10 : 2'b00, 1'b0);
      step(1'b0, 3'd0, 16'h0, 2'b00, 1'b1);
      idle(24);

      // requests at edge 12; WL=3 instance takes them as a restart
      step(1'b0, 3'd0, 16'h0, 2'b00, 1'b1);
      idle(11);
      step(1'b1, 3'd0, 16'hFFFF, 2'b00, 1'b1);
      idle(24);
      step(1'b0, 3'd0, 16'h0, 2'b00, 1'b1);
      idle(24);

      // reset in the middle of a burst, then a clean reload
      step(1'b0, 3'd0, 16'h0, 2'b00, 1'b1);
      idle(13);
      do_reset();
      load_rand();
      step(1'b0, 3'd0, 16'h0, 2'b00, 1'b1);
      idle(24);

      // random traffic
      repeat (600)
         step(1'($urandom_range(0, 1)), 3'($urandom),
              16'($urandom), 2'($urandom),
              1'($urandom_range(0, 9) == 0));
      idle(24);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule

// File: doc/ddr3_write_burst8.md
Name: ddr3_write_burst8

Overview:
- Write-direction counterpart of the DDR3 8-deep read capture ring buffer.
- Holds one burst-of-8 of 16-bit write data plus byte masks, loaded by the controller through an indexed write port.
- On a start pulse, waits the write latency and drives write preamble, 8 DQ beats with a toggling DQS, then postamble.
- Sits between the memory controller write path and the DQ/DQS pad drivers. The PHY delay line provides the quarter-cycle DQS shift.

Parameters:
- WL, 10: clk cycles from start edge to first data beat on dq_out; legal range 3..63.
- DW, 16: DQ width. DM width is DW/8.

Ports:
- clk  in  1  beat clock; one DDR beat per clk cycle.
- reset  in  1  asynchronous, active-high reset.
- load_en  in  1  write one buffer entry this cycle.
- load_ptr  in  3  buffer index 0..7 (beat order).
- load_data  in  DW  data for entry load_ptr.
- load_mask  in  DW/8  byte mask for entry load_ptr (1 = masked).
- load_ready  out  1  buffer writable (= ~busy).
- start  in  1  one-cycle request to transmit the buffered burst.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse in the postamble cycle.
- dq_out  out  DW  DQ drive data.
- dm_out  out  DW/8  DM drive data.
- dq_oe  out  1  DQ/DM output enable.
- dqs_out  out  1  DQS drive value.
- dqs_oe  out  1  DQS output enable.

Behaviour:
- Reset (async assert): state IDLE; beat and latency counters 0; all 8 buffer entries and masks 0; every output 0 except load_ready=1.
- Buffer:
  - When load_en=1 and busy=0, r[load_ptr] <= load_data and m[load_ptr] <= load_mask on clk rise.
  - load_en while busy=1 is ignored and the buffer is unchanged.
- Start:
  - start is sampled only in IDLE. start while busy is ignored, with no queuing.
  - If load_en and start are asserted in the same cycle, the load takes effect and the burst transmits the new value.
- Timing, with start sampled at edge 0:
  - WAIT, edges 1..WL-3: busy=1; dq_oe=dqs_oe=0. With WL=3, WAIT has zero cycles.
  - PRE, edges WL-2 and WL-1: dqs_oe=1, dqs_out=0, dq_oe=0.
  - BURST, edges WL..WL+7, beat k=0..7:
    - dq_oe=1, dqs_oe=1.
    - dq_out=r[k], dm_out=m[k].
    - dqs_out=1 for even k, 0 for odd k (rising DQS edge at beat 0).
  - POST, edge WL+8: dqs_oe=1, dqs_out=0, dq_oe=0, done=1.
  - IDLE, edge WL+9: busy=0, done=0, all enables 0. The earliest accepted restart is start sampled at edge WL+9.
- Idle output values: dq_out and dm_out are 0 whenever dq_oe=0. dqs_out is 0 whenever dqs_oe=0.
- All outputs are registered. No combinational path from inputs to outputs except load_ready, which is derived from the busy register.
- Latency counter: 6 bits. It loads WL-3 on start and decrements in WAIT. It must not wrap or underflow at WL=3.
- Beat counter: 3 bits, wraps 7->0 exactly at the BURST->POST transition.
- Reset mid-burst: outputs drop to 0 asynchronously, and the buffer contents are lost.

Test Plan:
- Reset then idle: assert reset mid-cycle -> all outputs 0 immediately, load_ready=1; after release, no activity for 20 cycles.
- Nominal burst, WL=10:
  - Stimulus: load r[k]=16'h1110+k with masks 0, then start at edge 0.
  - Required: dqs_oe high at edges 8..18; dqs_out 0,0,1,0,1,0,1,0,1,0,0.
  - Required: dq_out 1110..1117 at edges 10..17; done high at edge 18 only; busy low at edge 19.
- Mask and ptr order: load entries in reverse order (ptr 7..0) with m[3]=2'b10 -> dm_out=2'b10 only at beat 3; data still emitted in index order.
- Ignored requests: start and load_en ptr=0 data=FFFF at edge 12 during the burst -> burst unchanged, no second burst; r[0] still holds the old value on a subsequent burst.
- Minimum latency, WL=3: start at edge 0 -> preamble at edges 1-2, beats at 3..10, done at 11; back-to-back start at edge 12 -> preamble at 13.
- Reset mid-burst: reset at edge 14 with WL=10 -> all outputs 0 at once; a new start after release with the buffer reloaded produces a clean full burst.
